// File: rtl/chaotic_iter_ctrl.sv
// Run controller for the time-multiplexed chaotic-equation datapath.
// Issues SLOT_NUM slots per round for a programmable number of rounds,
// tracks returning results on the write side, and reports completion.
module chaotic_iter_ctrl #(
  parameter int SLOT_NUM = 245,
  parameter int ADDR_W   = 8,
  parameter int ITER_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] iter_num,
  input  logic              seed_en,
  input  logic              abort,
  input  logic              eq_n1_valid,
  output logic              eq_n_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              state_sel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err
);

  // One spare bit so a hazardous overshoot past SLOT_NUM is still counted.
  localparam int                OUT_W     = $clog2(SLOT_NUM + 1) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SLOT_NUM - 1);
  localparam logic [ITER_W-1:0] ROUND_MAX = {ITER_W{1'b1}};
  localparam logic [OUT_W-1:0]  SLOT_CNT  = OUT_W'(SLOT_NUM);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [ITER_W-1:0] rd_round_reg, rd_round_next;
  logic [ITER_W-1:0] wr_round_reg, wr_round_next;
  logic [ITER_W-1:0] iter_reg, iter_next;
  logic              seed_reg, seed_next;
  logic              aborted_reg, aborted_next;
  logic              err_reg, err_next;
  logic [OUT_W-1:0]  outst_reg, outst_next;

  logic              issue;
  logic              write;
  logic              ret;
  logic [ITER_W-1:0] iter_last;

  // A slot is issued every ISSUE cycle unless abort holds it back.
  assign issue     = (state_reg == ISSUE) && !abort;
  // Results are accepted in every active state; in IDLE they are stray.
  assign write     = (state_reg != IDLE) && eq_n1_valid;
  // Only count a return against something outstanding so a stray cannot underflow.
  assign ret       = write && ((outst_reg != '0) || issue);
  assign iter_last = iter_reg - ITER_W'(1);

  // Next-state, counter and flag logic.
  always_comb begin
    state_next    = state_reg;
    rd_addr_next  = rd_addr_reg;
    rd_round_next = rd_round_reg;
    wr_addr_next  = wr_addr_reg;
    wr_round_next = wr_round_reg;
    iter_next     = iter_reg;
    seed_next     = seed_reg;
    aborted_next  = aborted_reg;
    err_next      = err_reg;
    outst_next    = outst_reg;

    if (issue) begin
      if (rd_addr_reg == LAST_ADDR) begin
        rd_addr_next = '0;
        if (rd_round_reg != ROUND_MAX) rd_round_next = rd_round_reg + ITER_W'(1);
      end else begin
        rd_addr_next = rd_addr_reg + ADDR_W'(1);
      end
    end

    if (write) begin
      if (wr_addr_reg == LAST_ADDR) begin
        wr_addr_next = '0;
        if (wr_round_reg != ROUND_MAX) wr_round_next = wr_round_reg + ITER_W'(1);
      end else begin
        wr_addr_next = wr_addr_reg + ADDR_W'(1);
      end
    end

    if (issue && !ret)      outst_next = outst_reg + OUT_W'(1);
    else if (ret && !issue) outst_next = outst_reg - OUT_W'(1);

    if ((state_reg == ISSUE) && abort) aborted_next = 1'b1;

    // Stray result, or re-reading a slot whose previous result is not yet written.
    if (((state_reg == IDLE) && eq_n1_valid) || (issue && (outst_reg >= SLOT_CNT)))
      err_next = 1'b1;

    if ((state_reg == IDLE) && start) begin
      rd_addr_next  = '0;
      rd_round_next = '0;
      wr_addr_next  = '0;
      wr_round_next = '0;
      outst_next    = '0;
      iter_next     = iter_num;
      seed_next     = seed_en;
      aborted_next  = 1'b0;
    end

    case (state_reg)
      IDLE:    if (start) state_next = (iter_num == '0) ? DONE : ISSUE;
      ISSUE: begin
        if (abort)
          state_next = DRAIN;
        else if ((rd_addr_reg == LAST_ADDR) && (rd_round_reg == iter_last))
          state_next = DRAIN;
      end
      DRAIN:   if (outst_next == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rd_addr_reg  <= '0;
      rd_round_reg <= '0;
      wr_addr_reg  <= '0;
      wr_round_reg <= '0;
      iter_reg     <= '0;
      seed_reg     <= 1'b0;
      aborted_reg  <= 1'b0;
      err_reg      <= 1'b0;
      outst_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      rd_addr_reg  <= rd_addr_next;
      rd_round_reg <= rd_round_next;
      wr_addr_reg  <= wr_addr_next;
      wr_round_reg <= wr_round_next;
      iter_reg     <= iter_next;
      seed_reg     <= seed_next;
      aborted_reg  <= aborted_next;
      err_reg      <= err_next;
      outst_reg    <= outst_next;
    end
  end

  assign eq_n_valid = issue;
  assign rd_addr    = rd_addr_reg;
  assign state_sel  = issue && seed_reg && (rd_round_reg == '0);
  assign wr_en      = write;
  assign wr_addr    = wr_addr_reg;
  assign out_valid  = write && (wr_round_reg == iter_last) && !aborted_reg;
  assign busy       = (state_reg == ISSUE) || (state_reg == DRAIN);
  assign done       = (state_reg == DONE);
  assign aborted    = aborted_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_chaotic_iter_ctrl.sv
// Bench for chaotic_iter_ctrl: emulated fixed-latency datapath, transaction-level
// reference model compared every cycle, plus directed literal checks per scenario.
module tb_chaotic_iter_ctrl;
  localparam int S  = 4;
  localparam int AW = 3;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst, start, seed_en, abort, eq_n1_valid;
  logic [IW-1:0] iter_num;
  logic          eq_n_valid, state_sel, wr_en, out_valid, busy, done, aborted, err;
  logic [AW-1:0] rd_addr, wr_addr;

  always #5 clk = ~clk;

  chaotic_iter_ctrl #(.SLOT_NUM(S), .ADDR_W(AW), .ITER_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .iter_num(iter_num), .seed_en(seed_en),
    .abort(abort), .eq_n1_valid(eq_n1_valid), .eq_n_valid(eq_n_valid),
    .rd_addr(rd_addr), .state_sel(state_sel), .wr_en(wr_en), .wr_addr(wr_addr),
    .out_valid(out_valid), .busy(busy), .done(done), .aborted(aborted), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 2;
  bit cmp_en = 0;
  bit hist [64];

  // Reference model: run phase plus issued/written transaction counts.
  int m_mode = 0;  // 0 idle, 1 issuing, 2 draining, 3 done
  int m_iter = 0, m_k = 0, m_w = 0;
  bit m_seed = 0, m_aborted = 0, m_err = 0;

  // Per-scenario tallies of DUT behaviour.
  int clr_id = 0, clr_seen = 0;
  int n_issue, n_sel, n_wr, n_ov, n_busy, n_done, n_abt_done;
  int done_cyc, last_wr_cyc, err_cyc, r1_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: DUT outputs against the model, then advance the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      automatic bit e_issue = (m_mode == 1) && !abort;
      automatic bit e_write = (m_mode != 0) && eq_n1_valid;
      automatic bit e_ov    = e_write && (m_w / S == m_iter - 1) && !m_aborted;
      if (clr_id != clr_seen) begin
        clr_seen = clr_id;
        n_issue = 0; n_sel = 0; n_wr = 0; n_ov = 0; n_busy = 0; n_done = 0;
        n_abt_done = 0; done_cyc = -1; last_wr_cyc = -1; err_cyc = -1; r1_cyc = -1;
      end
      chk("eq_n_valid", eq_n_valid, e_issue);
      chk("rd_addr",    rd_addr,    m_k % S);
      chk("state_sel",  state_sel,  e_issue && m_seed && (m_k < S));
      chk("wr_en",      wr_en,      e_write);
      chk("wr_addr",    wr_addr,    m_w % S);
      chk("out_valid",  out_valid,  e_ov);
      chk("busy",       busy,       (m_mode == 1) || (m_mode == 2));
      chk("done",       done,       m_mode == 3);
      chk("aborted",    aborted,    m_aborted);
      chk("err",        err,        m_err);

      if (eq_n_valid === 1'b1) n_issue++;
      if (state_sel === 1'b1)  n_sel++;
      if (wr_en === 1'b1) begin n_wr++; last_wr_cyc = cyc; end
      if (out_valid === 1'b1)  n_ov++;
      if (busy === 1'b1)       n_busy++;
      if (done === 1'b1) begin n_done++; done_cyc = cyc; if (aborted === 1'b1) n_abt_done++; end
      if ((err === 1'b1) && (err_cyc < 0)) err_cyc = cyc;
      if (e_issue && (m_k == S)) r1_cyc = cyc;
      hist[cyc % 64] = (eq_n_valid === 1'b1);

      if (rst) begin
        m_mode = 0; m_iter = 0; m_k = 0; m_w = 0; m_seed = 0; m_aborted = 0; m_err = 0;
      end else begin
        if ((m_mode == 0) && eq_n1_valid) m_err = 1;
        if (e_issue && (m_k - m_w >= S)) m_err = 1;
        if (e_write) m_w++;
        case (m_mode)
          0: if (start) begin
               m_k = 0; m_w = 0; m_aborted = 0;
               m_iter = int'(iter_num); m_seed = seed_en;
               m_mode = (iter_num == 0) ? 3 : 1;
             end
          1: if (abort) begin
               m_aborted = 1; m_mode = 2;
             end else begin
               m_k++;
               if (m_k == m_iter * S) m_mode = 2;
             end
          2: if (m_k == m_w) m_mode = 3;
          default: m_mode = 0;
        endcase
      end
    end else begin
      hist[cyc % 64] = 1'b0;
    end
  end

  // Advance one cycle; the datapath returns each issue exactly lat cycles later.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    start = 1'b0;
    abort = 1'b0;
    eq_n1_valid = (cyc >= lat) ? hist[(cyc - lat) % 64] : 1'b0;
  endtask

  task automatic rst_pulse();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
  endtask

  task automatic begin_run(input int it, input bit sd);
    tick();
    clr_id++;
    start = 1'b1; iter_num = IW'(it); seed_en = sd;
  endtask

  task automatic wait_idle(input int bound, input int abort_at, input int abort_pct, input int noise_pct);
    int n = 0;
    do begin
      tick();
      n++;
      if ((m_mode == 1) && (m_k == abort_at)) abort = 1'b1;
      if ((m_mode == 1) && ($urandom_range(0, 99) < abort_pct)) abort = 1'b1;
      if ((m_mode != 0) && ($urandom_range(0, 99) < noise_pct)) begin
        start = 1'b1; iter_num = IW'($urandom_range(0, 7));
      end
    end while ((m_mode != 0) && (n < bound));
    checks++;
    if (m_mode != 0) begin
      errors++;
      $display("FAIL run_timeout act=busy exp=idle after %0d cycles", n);
    end
  endtask

  initial begin
    int st_cyc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; eq_n1_valid = 1'b0; iter_num = '0; seed_en = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    tick(); rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_err", err, 0);
    chk("reset_rd_addr", rd_addr, 0);

    // Two rounds with seed, latency 2.
    lat = 2;
    begin_run(2, 1'b1);
    wait_idle(100, -1, 0, 0);
    chk("t1_issues", n_issue, 8);
    chk("t1_state_sel", n_sel, 4);
    chk("t1_writes", n_wr, 8);
    chk("t1_out_valid", n_ov, 4);
    chk("t1_done_after_last_wr", done_cyc - last_wr_cyc, 1);
    chk("t1_err", err, 0);
    $display("run t1 iter=2 issued=%0d written=%0d final=%0d", n_issue, n_wr, n_ov);

    // Zero rounds: immediate done.
    begin_run(0, 1'b0);
    st_cyc = cyc;
    wait_idle(10, -1, 0, 0);
    chk("t2_done_next", done_cyc - st_cyc, 1);
    chk("t2_issues", n_issue, 0);
    chk("t2_writes", n_wr, 0);
    chk("t2_busy", n_busy, 0);
    $display("run t2 iter=0 done_after=%0d", done_cyc - st_cyc);

    // Abort in round 1 at slot 2.
    begin_run(3, 1'b0);
    wait_idle(100, S + 2, 0, 0);
    chk("t3_issues", n_issue, 6);
    chk("t3_writes", n_wr, 6);
    chk("t3_out_valid", n_ov, 0);
    chk("t3_done_aborted", n_abt_done, 1);
    $display("run t3 iter=3 abort issued=%0d written=%0d", n_issue, n_wr);

    // Latency too long for 4 slots: hazard flagged on first round-1 issue.
    rst_pulse();
    lat = 5;
    begin_run(2, 1'b0);
    wait_idle(100, -1, 0, 0);
    chk("t4_err", err, 1);
    chk("t4_err_timing", err_cyc - r1_cyc, 1);
    chk("t4_done", n_done, 1);
    $display("run t4 iter=2 lat=5 err=%0d", err);
    repeat (8) tick();

    // Stray result in IDLE, then a start pulse in the middle of a run.
    rst_pulse();
    lat = 2;
    repeat (3) tick();
    tick(); clr_id++; eq_n1_valid = 1'b1;
    tick();
    chk("t5_stray_err", err, 1);
    chk("t5_stray_wr", n_wr, 0);
    chk("t5_stray_wr_addr", wr_addr, 0);
    begin_run(2, 1'b0);
    repeat (3) tick();
    start = 1'b1; iter_num = IW'(7);
    wait_idle(100, -1, 0, 0);
    chk("t5_issues", n_issue, 8);
    $display("run t5 iter=2 restart_ignored issued=%0d", n_issue);

    // Reset in the middle of issuing.
    rst_pulse();
    begin_run(3, 1'b1);
    repeat (5) tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_rd_addr", rd_addr, 0);
    chk("t6_err", err, 0);
    repeat (8) tick();
    rst_pulse();
    begin_run(1, 1'b0);
    wait_idle(100, -1, 0, 0);
    chk("t6_rerun_issues", n_issue, 4);
    chk("t6_rerun_err", err, 0);
    $display("run t6 mid-run reset then iter=1 issued=%0d", n_issue);

    // Randomized runs.
    for (int r = 0; r < 25; r++) begin
      int it;
      bit sd;
      if ($urandom_range(0, 4) == 0) rst_pulse();
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 5) == 0) begin tick(); eq_n1_valid = 1'b1; end
      tick();
      lat = $urandom_range(1, 2);
      it = $urandom_range(0, 3);
      sd = 1'($urandom_range(0, 1));
      begin_run(it, sd);
      wait_idle(200, -1, 4, 10);
      $display("run r%0d iter=%0d seed=%0d lat=%0d issued=%0d written=%0d aborted=%0d err=%0d",
               r, it, sd, lat, n_issue, n_wr, aborted, err);
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/chaotic_iter_ctrl.md
Name: chaotic_iter_ctrl

Overview:
- Run controller for the time-multiplexed chaotic-equation datapath.
- The datapath carries SLOT_NUM independent trajectories, one per parameter-ROM/state-RAM address. Each address is issued once per round.
- On a start command, the block:
  - sequences a programmable number of rounds;
  - drives the shared ROM/RAM read address, the equation-input valid and the state-RAM write address/enable;
  - selects seed or feedback state in the first round;
  - flags final-round outputs, drains in-flight results and reports done/abort/errors.

Parameters:
SLOT_NUM, 245, trajectories per round; read/write addresses run 0..SLOT_NUM-1 then wrap.
ADDR_W, 8, address width; must satisfy 2^ADDR_W >= SLOT_NUM.
ITER_W, 16, round-count width.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
start  in  1  one-cycle run request; accepted only in IDLE.
iter_num  in  ITER_W  rounds to run; sampled with start.
seed_en  in  1  1 = round 0 takes state from the seed source; sampled with start.
abort  in  1  stop issuing; finish in-flight results.
eq_n1_valid  in  1  datapath output valid.
eq_n_valid  out  1  datapath input valid.
rd_addr  out  ADDR_W  shared ROM/RAM read address.
state_sel  out  1  1 = datapath state input from seed source.
wr_en  out  1  state-RAM write enable.
wr_addr  out  ADDR_W  state-RAM write address.
out_valid  out  1  current eq_n1_valid belongs to the final round.
busy  out  1  high in ISSUE and DRAIN.
done  out  1  one-cycle completion pulse.
aborted  out  1  qualifies done; holds until next accepted start.
err  out  1  sticky: stray output or read-before-write hazard; cleared by rst only.

Behaviour:
- Reset state: IDLE. All outputs 0; all counters 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start with iter_num != 0: latch iter_num and seed_en, clear aborted, go to ISSUE.
  - start with iter_num == 0: go to DONE; no issue occurs.
  - start while not in IDLE is ignored.
- ISSUE:
  - eq_n_valid = 1 every cycle.
  - rd_addr counts 0..SLOT_NUM-1, then wraps to 0. Each wrap increments rd_round.
  - state_sel = seed_latched && rd_round == 0.
  - Leave to DRAIN after issuing rd_addr == SLOT_NUM-1 with rd_round == iter-1. Total issued = iter*SLOT_NUM.
  - abort=1: no issue that cycle, eq_n_valid=0, set aborted, go to DRAIN.
  - Simultaneous abort and final issue: abort wins, and that slot is not issued.
- Write side (any state except IDLE):
  - wr_en = eq_n1_valid.
  - wr_addr is the slot of the current result. It advances after each eq_n1_valid, wrapping at SLOT_NUM-1→0. Each wrap increments wr_round.
  - out_valid = eq_n1_valid && wr_round == iter-1 && !aborted.
- Outstanding counter:
  - +1 per issue, −1 per eq_n1_valid; both in the same cycle means no change.
  - Width: enough bits to hold SLOT_NUM.
- DRAIN: eq_n_valid = 0. When outstanding == 0 (including a return in the same cycle), go to DONE.
- DONE: done = 1 for one cycle, then IDLE. busy is low in DONE.
- Hazard check: an issue while outstanding >= SLOT_NUM means slot i would be re-read before its previous result was written. Set err; keep running.
- Latency requirement: the datapath's n_valid→n1_valid latency plus 2 (RAM read and write) must not exceed SLOT_NUM for hazard-free operation.
- Stray output: eq_n1_valid in IDLE sets err. It produces no write and does not move wr_addr.
- Counter behaviour: rd_round and wr_round saturate at 2^ITER_W−1. Address and round counters reset to 0 on every accepted start.
- rst mid-run: immediate return to IDLE. All outputs and counters are 0 next cycle, err is cleared, and in-flight datapath results are then stray.

Test Plan:
1. SLOT_NUM=4, start iter_num=2 seed_en=1, datapath latency 2:
   - eq_n_valid high 8 cycles; rd_addr 0,1,2,3,0,1,2,3.
   - state_sel high for the first 4 only.
   - 8 writes with wr_addr 0..3,0..3; out_valid on the last 4.
   - done one cycle after the last return; err=0.
2. start iter_num=0 → done pulse next cycle; eq_n_valid, wr_en and busy never assert.
3. abort during round 1 at rd_addr=2 (SLOT_NUM=4, iter 3, latency 2):
   - Slot 2 is not issued; issuing stops.
   - All 6 issued results are written; out_valid never asserts.
   - done with aborted=1.
4. Hazard: SLOT_NUM=4, latency 5, iter 2 → err=1 latched on the first round-1 issue; run still completes with done.
5. Stray eq_n1_valid pulse in IDLE → err=1, wr_en=0, wr_addr stays 0. start during ISSUE is ignored, with round count unchanged.
6. rst asserted mid-ISSUE → next cycle all outputs 0 and state IDLE; a new start then runs normally from rd_addr=0.
